// File: rtl/sa_lru_tracker_if.sv
// Op/read bus for the LRU tracker: the cache controller is the master,
// the tracker is the slave.
interface sa_lru_tracker_if #(
    parameter int WAYS = 4,
    parameter int SETS = 16
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic             ready;
    logic             op_valid;
    logic             op_inval;
    logic [SET_W-1:0] op_set;
    logic [WAY_W-1:0] op_way;
    logic [SET_W-1:0] rd_set;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] mru_way;

    modport master (
        input  ready, lru_way, mru_way,
        output op_valid, op_inval, op_set, op_way, rd_set
    );

    modport slave (
        output ready, lru_way, mru_way,
        input  op_valid, op_inval, op_set, op_way, rd_set
    );
endinterface

// File: rtl/sa_lru_tracker.sv
// True-LRU tracker: one recency list per set, slot[0] = LRU, slot[WAYS-1] = MRU.
// Touch moves a way to MRU, invalidate moves it to LRU; out-of-range
// operands are dropped. Reads are combinational from the stored lists.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | walking sets 0..SETS-1, writing identity order; ops ignored
//   ST_RUN  | ready=1, one op per cycle applied to the addressed set
module sa_lru_tracker #(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    sa_lru_tracker_if.slave bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SET_W-1:0] init_cnt_q, init_cnt_d;

    logic [WAY_W-1:0] slot_q [SETS][WAYS];
    logic [WAY_W-1:0] slot_d [SETS][WAYS];

    logic op_set_ok;
    logic op_way_ok;
    logic op_en;
    int   pos;

    // Range checks are done one bit wider so that power-of-two configs
    // do not produce a constant comparison.
    assign op_set_ok = ({1'b0, bus.op_set} < (SET_W + 1)'(SETS));
    assign op_way_ok = ({1'b0, bus.op_way} < (WAY_W + 1)'(WAYS));
    assign op_en     = !RST && (state_q == ST_RUN) && bus.op_valid
                       && op_set_ok && op_way_ok;

    assign bus.ready = (state_q == ST_RUN);

    // FSM state and init-walk counter; reset restarts the walk from set 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next-state: one set per cycle during init, then stay in RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == SET_W'(SETS - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + SET_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Next list contents: identity write during init, touch/invalidate in RUN.
    always_comb begin
        slot_d = slot_q;
        pos    = 0;
        for (int s = 0; s < SETS; s++) begin
            if (!RST && (state_q == ST_INIT) && (init_cnt_q == SET_W'(s))) begin
                for (int i = 0; i < WAYS; i++) begin
                    slot_d[s][i] = WAY_W'(i);
                end
            end
            if (op_en && (bus.op_set == SET_W'(s))) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (slot_q[s][i] == bus.op_way) begin
                        pos = i;
                    end
                end
                if (!bus.op_inval) begin
                    // Entries above the hit slide toward LRU, hit lands at MRU.
                    for (int i = 0; i < WAYS - 1; i++) begin
                        if (i >= pos) begin
                            slot_d[s][i] = slot_q[s][i + 1];
                        end
                    end
                    slot_d[s][WAYS - 1] = bus.op_way;
                end else begin
                    // Entries below the hit slide toward MRU, hit lands at LRU.
                    for (int i = 1; i < WAYS; i++) begin
                        if (i <= pos) begin
                            slot_d[s][i] = slot_q[s][i - 1];
                        end
                    end
                    slot_d[s][0] = bus.op_way;
                end
            end
        end
    end

    // List storage; no reset needed since init rewrites every set.
    always_ff @(posedge CLK) begin
        slot_q <= slot_d;
    end

    // Victim/MRU read mux; an out-of-range rd_set reads as way 0.
    always_comb begin
        bus.lru_way = '0;
        bus.mru_way = '0;
        for (int s = 0; s < SETS; s++) begin
            if (bus.rd_set == SET_W'(s)) begin
                bus.lru_way = slot_q[s][0];
                bus.mru_way = slot_q[s][WAYS - 1];
            end
        end
    end

endmodule

// File: doc/sa_lru_tracker.md
Name: sa_lru_tracker

Overview:
- Parametrised true-LRU replacement tracker for the set-associative cache.
- Keeps one full recency ordering of WAYS ways for each of SETS cache sets.
- The cache controller uses it three ways:
  - touches the accessed way on every hit or fill;
  - demotes a way to LRU on invalidation;
  - reads the victim way (LRU) of any set combinationally.
- Generalises the fixed 4-way, single-set queue to arbitrary way count, per-set state, an invalidate mode and a post-reset init sequence.

Parameters:
- WAYS, 4, associativity; must be >= 2.
- SETS, 16, number of cache sets tracked; must be >= 1.
- WAY_W, $clog2(WAYS), width of a way index (derived; do not override).
- SET_W, (SETS > 1) ? $clog2(SETS) : 1, width of a set index (derived).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ready  out  1  high when the init walk is done and ops are accepted.
- op_valid  in  1  an op is presented this cycle.
- op_inval  in  1  0 = touch (make MRU), 1 = invalidate (make LRU).
- op_set  in  SET_W  set the op targets.
- op_way  in  WAY_W  way the op targets.
- rd_set  in  SET_W  set whose LRU/MRU is read.
- lru_way  out  WAY_W  LRU way of rd_set; combinational from state.
- mru_way  out  WAY_W  MRU way of rd_set; combinational from state.

Behaviour:
- State: per set, an ordered list slot[0..WAYS-1] of way indices.
  - slot[0] = LRU, slot[WAYS-1] = MRU.
  - Invariant: each list is a permutation of 0..WAYS-1.
- lru_way = slot[0] of rd_set; mru_way = slot[WAYS-1] of rd_set.
- FSM has two states, INIT and RUN.
- INIT:
  - Entered on RST=1, from any state and mid-op.
  - While RST=1, ready=0 and an internal set counter is held at 0.
  - After RST falls: one set per cycle, counter 0..SETS-1, each set is written to the identity order slot[i]=i.
  - Takes SETS cycles; ready stays 0 throughout and op_valid is ignored.
  - After the last set is written, the FSM enters RUN and ready=1 from the next cycle.
  - Sets not yet initialised read undefined until written; the bench must not check lru_way/mru_way while ready=0.
- RUN, touch (op_valid=1, op_inval=0):
  - Find position p with slot[p]==op_way.
  - Shift slot[p+1..WAYS-1] down by one; write op_way to slot[WAYS-1].
  - If p==WAYS-1, there is no change.
- RUN, invalidate (op_valid=1, op_inval=1):
  - Find p.
  - Shift slot[0..p-1] up by one; write op_way to slot[0].
  - If p==0, there is no change.
- Illegal operands, both silently ignored (no state change):
  - op_way >= WAYS, possible when WAYS is not a power of 2;
  - op_set >= SETS.
- Only the addressed set changes; all other sets hold.
- Latency: one op per cycle, fully pipelined. The update is visible on lru_way/mru_way the cycle after op_valid.
- Read during write: if rd_set==op_set in the same cycle, the outputs show the pre-update order.
- Back-to-back ops to the same set in consecutive cycles apply in order with no stall. The second op sees the first op's result.
- No back-pressure beyond ready. ready never drops in RUN except on RST.
- Storage: flop array of SETS*WAYS*WAY_W bits. No RAM inference is required.

Test Plan:
- Init walk, WAYS=4, SETS=16:
  - RST for 2 cycles, then release.
  - ready stays 0 for exactly 16 cycles, then rises.
  - Every set then reads lru_way=0, mru_way=3.
  - op_valid pulses during init have no effect.
- Touch sequence on set 5:
  - Touch ways 0, 2, 0 (order becomes 1,3,2,0).
  - lru_way=1, mru_way=0.
  - Set 4 is unchanged (lru_way=0, mru_way=3).
- Invalidate on set 5 after the touch sequence: invalidate way 2.
  - Order becomes 2,1,3,0; lru_way=2, mru_way=0.
  - Invalidating way 2 again leaves the order unchanged.
- Read during write: rd_set=op_set=7, touch way 0 on an identity set.
  - Same cycle: lru_way=0.
  - Next cycle: lru_way=1, mru_way=0.
- Reset mid-operation: after random ops, assert RST for 1 cycle in RUN.
  - ready=0 immediately next cycle.
  - Init rewalks all SETS; all sets return to identity order.
- Non-power-of-2 config, WAYS=3, SETS=1:
  - A touch with op_way=3 is ignored; order stays 0,1,2.
  - Then touch way 0 -> lru_way=1, mru_way=0.
  - Random-op run checks against a reference model that every list stays a permutation.
